// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, writeback request type, requester ids and address-match helper
// No ports; imported by wb_fifo, wb_arbiter and the testbench.
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } wb_requester_e;
    function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] q, input logic [REG_ADDR_W-1:0] a,
                                      input logic v);
        return v && (q != '0) && (q == a);
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: per-requester writeback buffer with per-entry valid/addr taps for pending-register lookup
// clk, rst_n   : clock, async active-low reset
// i_push/i_din : enqueue (caller guarantees not full)
// i_pop        : dequeue head (caller guarantees not empty)
// o_head       : current head entry
// o_count      : occupancy
// o_vld/o_addr : per-slot valid bit and destination register
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_push,
    input  wb_req_t                              i_din,
    input  logic                                 i_pop,
    output wb_req_t                              o_head,
    output logic [$clog2(DEPTH):0]               o_count,
    output logic [DEPTH-1:0]                     o_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    // Push never targets a live slot and pop never targets an empty one,
    // so the valid-bit set and clear below can never hit the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_vld[r_wr] <= 1'b1;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_vld[r_rd] <= 1'b0;
                r_rd        <= r_rd + 1'b1;
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end
    always_comb begin
        o_addr = '0;
        for (int i = 0; i < DEPTH; i++) o_addr[i] = r_mem[i].addr;
    end
    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;
    assign o_vld   = r_vld;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of ALU and LSU writebacks onto one register-file write port
// clk, reset                     : clock, async active-low reset
// alu_* / lsu_*                  : valid/ready writeback requests (addr 5b, data 32b)
// rf_write_*                     : register-file write port, driven straight from the granted head
// query_addrN / query_pendingN   : decode hazard lookup against all buffered writes
// idle                           : both buffers empty
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0]     lsu_data,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_reg_addr,
    output logic [DATA_W-1:0]     rf_write_data,
    input  logic [REG_ADDR_W-1:0] query_addr1,
    input  logic [REG_ADDR_W-1:0] query_addr2,
    output logic                  query_pending1,
    output logic                  query_pending2,
    output logic                  idle
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [CW-1:0]                            w_alu_cnt, w_lsu_cnt;
    wb_req_t                                  w_alu_head, w_lsu_head, w_head;
    logic [FIFO_DEPTH-1:0]                    w_alu_vld, w_lsu_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]    w_alu_addr, w_lsu_addr;
    logic                                     w_alu_push, w_lsu_push, w_alu_pop, w_lsu_pop;
    logic                                     w_alu_ne, w_lsu_ne;
    wb_requester_e                            r_last;
    assign alu_ready  = w_alu_cnt < CW'(FIFO_DEPTH);
    assign lsu_ready  = w_lsu_cnt < CW'(FIFO_DEPTH);
    // x0 writes complete the handshake but are never buffered.
    assign w_alu_push = alu_valid && alu_ready && (alu_addr != '0);
    assign w_lsu_push = lsu_valid && lsu_ready && (lsu_addr != '0);
    assign w_alu_ne   = w_alu_cnt != '0;
    assign w_lsu_ne   = w_lsu_cnt != '0;
    // LSU wins when it is alone, or when contended and ALU took the last grant.
    assign w_lsu_pop  = w_lsu_ne && (!w_alu_ne || r_last == REQ_ALU);
    assign w_alu_pop  = w_alu_ne && !w_lsu_pop;
    assign w_head     = w_lsu_pop ? w_lsu_head : w_alu_head;
    assign rf_write_enable   = w_alu_ne || w_lsu_ne;
    assign rf_write_reg_addr = rf_write_enable ? w_head.addr : '0;
    assign rf_write_data     = rf_write_enable ? w_head.data : '0;
    assign idle              = !rf_write_enable;
    // Reset to LSU so ALU wins the first contended grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_last <= REQ_LSU;
        else if (rf_write_enable) r_last <= w_lsu_pop ? REQ_LSU : REQ_ALU;
    end
    always_comb begin
        query_pending1 = 1'b0;
        query_pending2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            query_pending1 = query_pending1 | addr_hit(query_addr1, w_alu_addr[i], w_alu_vld[i])
                                            | addr_hit(query_addr1, w_lsu_addr[i], w_lsu_vld[i]);
            query_pending2 = query_pending2 | addr_hit(query_addr2, w_alu_addr[i], w_alu_vld[i])
                                            | addr_hit(query_addr2, w_lsu_addr[i], w_lsu_vld[i]);
        end
    end
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_alu_push),
        .i_din   ({alu_addr, alu_data}),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_count (w_alu_cnt),
        .o_vld   (w_alu_vld),
        .o_addr  (w_alu_addr)
    );
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_lsu_push),
        .i_din   ({lsu_addr, lsu_data}),
        .i_pop   (w_lsu_pop),
        .o_head  (w_lsu_head),
        .o_count (w_lsu_cnt),
        .o_vld   (w_lsu_vld),
        .o_addr  (w_lsu_addr)
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed-vector bench for wb_arbiter with a negedge commit logger
module tb_wb_arbiter;
    import wb_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_addr = '0, lsu_addr = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  query_addr1 = '0, query_addr2 = '0;
    logic        query_pending1, query_pending2, idle;
    int          n_vec = 0;
    int          n_err = 0;
    wb_req_t     log_q[$];
    logic [7:0]  lrdy;
    always #5 clk = ~clk;
    wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_addr          (alu_addr),
        .alu_data          (alu_data),
        .lsu_valid         (lsu_valid),
        .lsu_ready         (lsu_ready),
        .lsu_addr          (lsu_addr),
        .lsu_data          (lsu_data),
        .rf_write_enable   (rf_write_enable),
        .rf_write_reg_addr (rf_write_reg_addr),
        .rf_write_data     (rf_write_data),
        .query_addr1       (query_addr1),
        .query_addr2       (query_addr2),
        .query_pending1    (query_pending1),
        .query_pending2    (query_pending2),
        .idle              (idle)
    );
    // The head shown at negedge is what the following rising edge writes.
    always @(negedge clk) if (reset && rf_write_enable) log_q.push_back({rf_write_reg_addr, rf_write_data});
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        reset = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        log_q.delete();
    endtask
    task automatic run_streams(input int n, input logic [4:0] ab, input logic [4:0] lb, output logic [7:0] rdy);
        int  ia = 0;
        int  il = 0;
        bit  acc_a, acc_l;
        rdy = '0;
        for (int k = 0; k < 4 * n + 6; k++) begin
            alu_valid = ia < n;
            alu_addr  = 5'(ab + ia);
            alu_data  = 32'hA000_0000 + 32'(ab + ia);
            lsu_valid = il < n;
            lsu_addr  = 5'(lb + il);
            lsu_data  = 32'hB000_0000 + 32'(lb + il);
            #1;
            if (k < 8) rdy[k] = lsu_ready;
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            step();
            ia += int'(acc_a);
            il += int'(acc_l);
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("stream_count", 64'(log_q.size()), 64'(2 * n));
        for (int j = 0; j < 2 * n && j < log_q.size(); j++) begin
            logic [4:0] a;
            a = (j % 2 == 0) ? 5'(ab + j / 2) : 5'(lb + j / 2);
            check($sformatf("stream_commit%0d", j), 64'(log_q[j]),
                  64'({a, ((j % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(a)}));
        end
    endtask
    initial begin
        #1;
        check("rst_alu_ready", 64'(alu_ready), 64'd1);
        check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        check("rst_we", 64'(rf_write_enable), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        // single ALU write x5
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        check("t30_ready", 64'(alu_ready), 64'd1);
        check("t30_no_bypass", 64'(rf_write_enable), 64'd0);
        step();
        alu_valid = 1'b0;
        #1;
        check("t30_we", 64'(rf_write_enable), 64'd1);
        check("t30_addr", 64'(rf_write_reg_addr), 64'd5);
        check("t30_data", 64'(rf_write_data), 64'hDEAD_BEEF);
        check("t30_busy", 64'(idle), 64'd0);
        step();
        check("t30_we_off", 64'(rf_write_enable), 64'd0);
        check("t30_addr_zero", 64'(rf_write_reg_addr), 64'd0);
        check("t30_data_zero", 64'(rf_write_data), 64'd0);
        check("t30_idle", 64'(idle), 64'd1);
        // alternating commits, ALU first
        do_reset();
        run_streams(4, 5'd1, 5'd9, lrdy);
        // LSU backpressure against a permanently busy ALU
        do_reset();
        run_streams(6, 5'd17, 5'd23, lrdy);
        check("t32_lsu_rdy0", 64'(lrdy[0]), 64'd1);
        check("t32_lsu_rdy1", 64'(lrdy[1]), 64'd1);
        check("t32_lsu_rdy2_full", 64'(lrdy[2]), 64'd0);
        check("t32_idle_end", 64'(idle), 64'd1);
        // x0 write is swallowed
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234; query_addr1 = 5'd0;
        #1;
        check("t33_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        #1;
        check("t33_no_we", 64'(rf_write_enable), 64'd0);
        check("t33_idle", 64'(idle), 64'd1);
        check("t33_pending", 64'(query_pending1), 64'd0);
        step();
        check("t33_no_we2", 64'(rf_write_enable), 64'd0);
        // pending lookup across both FIFOs, including the committing head
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h77;
        query_addr1 = 5'd7; query_addr2 = 5'd2;
        #1;
        check("t34_p1_pre", 64'(query_pending1), 64'd0);
        check("t34_p2_pre", 64'(query_pending2), 64'd0);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        check("t34_p1_buf", 64'(query_pending1), 64'd1);
        check("t34_p2_buf", 64'(query_pending2), 64'd1);
        check("t34_addr_alu", 64'(rf_write_reg_addr), 64'd2);
        step();
        check("t34_p1_head", 64'(query_pending1), 64'd1);
        check("t34_p2_done", 64'(query_pending2), 64'd0);
        check("t34_addr_lsu", 64'(rf_write_reg_addr), 64'd7);
        check("t34_data_lsu", 64'(rf_write_data), 64'h77);
        step();
        check("t34_p1_done", 64'(query_pending1), 64'd0);
        check("t34_idle", 64'(idle), 64'd1);
        // reset with three entries buffered
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'hD13;
        lsu_valid = 1'b1; lsu_addr = 5'd14; lsu_data = 32'hD14;
        step();
        alu_addr = 5'd15; alu_data = 32'hD15;
        lsu_addr = 5'd16; lsu_data = 32'hD16;
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        query_addr1 = 5'd15; query_addr2 = 5'd16;
        #1;
        check("t35_busy", 64'(idle), 64'd0);
        check("t35_lsu_head", 64'(rf_write_reg_addr), 64'd14);
        check("t35_p1_before", 64'(query_pending1), 64'd1);
        reset = 1'b0;
        #1;
        check("t35_alu_ready", 64'(alu_ready), 64'd1);
        check("t35_lsu_ready", 64'(lsu_ready), 64'd1);
        check("t35_we", 64'(rf_write_enable), 64'd0);
        check("t35_addr", 64'(rf_write_reg_addr), 64'd0);
        check("t35_data", 64'(rf_write_data), 64'd0);
        check("t35_p1", 64'(query_pending1), 64'd0);
        check("t35_p2", 64'(query_pending2), 64'd0);
        check("t35_idle", 64'(idle), 64'd1);
        step();
        step();
        reset = 1'b1;
        repeat (4) step();
        check("t35_log_size", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) check("t35_log0", 64'(log_q[0]), 64'({5'd13, 32'hD13}));
        check("t35_idle_after", 64'(idle), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, entries buffered per requester (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports alu_valid/alu_ready  input/output  1/1  ALU writeback handshake.
REQ-005 SHALL have ports alu_addr/alu_data  input  5/32  ALU destination register and value.
REQ-006 SHALL have ports lsu_valid/lsu_ready  input/output  1/1  load-unit writeback handshake.
REQ-007 SHALL have ports lsu_addr/lsu_data  input  5/32  load destination register and value.
REQ-008 SHALL have ports rf_write_enable/rf_write_reg_addr/rf_write_data  output  1/5/32  register-file write port.
REQ-009 SHALL have ports query_addr1/query_addr2  input  5  source registers being read by decode.
REQ-010 SHALL have ports query_pending1/query_pending2  output  1  a buffered write targets that register.
REQ-011 SHALL have port idle  output  1  both FIFOs empty.

Function
REQ-012 SHALL accept a request on a rising edge where valid && ready; ready SHALL be high exactly when that requester's FIFO count < FIFO_DEPTH, independent of valid and of same-cycle pops.
REQ-013 SHALL accept writes with addr 0 and discard them: no enqueue, no rf write, never pending.
REQ-014 SHALL drive rf_write_* combinationally from the granted FIFO head; rf_write_enable high iff at least one FIFO non-empty; granted head popped on the same edge.
REQ-015 SHALL commit an entry accepted at edge k no earlier than edge k+1 (zero-bypass, 1-cycle minimum latency).
REQ-016 SHALL grant the only non-empty FIFO when one is non-empty; when both non-empty, SHALL grant the requester not granted most recently (round-robin pointer updated on each grant).
REQ-017 SHALL preserve per-requester order (FIFO); no ordering between requesters beyond REQ-016 is guaranteed, and the issue logic SHALL not issue two in-flight writes to one register from different units.
REQ-018 SHALL hold rf_write_reg_addr and rf_write_data at 0 when rf_write_enable is low.
REQ-019 SHALL assert query_pendingN iff queryN is nonzero and matches the addr of any valid entry in either FIFO, including the head being written this cycle.
REQ-020 SHALL handle simultaneous enqueue and pop on the same FIFO: count unchanged, order kept.
REQ-021 SHALL wrap read/write pointers modulo FIFO_DEPTH without loss or duplication.
REQ-022 SHALL guarantee any non-empty FIFO is granted within 2 cycles (no starvation).
REQ-023 SHALL assert idle iff both counts are 0.

Reset
REQ-024 SHALL on reset low, immediately clear all FIFO entries, counts and pointers, and set the round-robin pointer so ALU wins the first contended grant.
REQ-025 SHALL hold outputs during reset at: ready=1 both, rf_write_enable=0, rf_write_reg_addr=0, rf_write_data=0, query_pending=0, idle=1.
REQ-026 SHALL drop buffered writes when reset asserts mid-operation; no rf write on the reset-release edge.

Structure
REQ-027 SHALL place REG_ADDR_W=5, DATA_W=32, wb_req_t {addr, data} and requester enum {REQ_ALU, REQ_LSU} in shared package wb_pkg.
REQ-028 SHALL implement each buffer as an instance of sub-module wb_fifo (parameterised depth, count, valid-entry addr outputs for the pending compare).
REQ-029 SHALL connect to the register file's write port directly with no extra register stage.

Verification
REQ-030 SHALL test: ALU writes x5=0xDEADBEEF alone -> rf_write_enable high next cycle with addr 5, data 0xDEADBEEF, idle then 1.
REQ-031 SHALL test: both valid every cycle, ALU x1..x4, LSU x9..x12 -> commits alternate ALU,LSU,... starting ALU after reset, each stream in order.
REQ-032 SHALL test: LSU holds valid with ALU always non-empty -> lsu_ready drops at count 2, LSU granted every second cycle, no entry lost.
REQ-033 SHALL test: ALU writes x0=0x1234 -> accepted, no rf write, query_pending for x0 stays 0.
REQ-034 SHALL test: buffer x7 in LSU FIFO, query_addr1=7 -> query_pending1=1 until edge x7 commits, 0 after.
REQ-035 SHALL test: reset pulsed with 3 entries buffered -> outputs at REQ-025 values immediately, none of the 3 writes ever appears.
